// File: rtl/dbg_uart_cmd.sv
// dbg_uart_cmd: binary UART debug command engine.
// Parses host commands and drives the dbg register bus.
module dbg_uart_cmd #(
    parameter int ACCESS_TIMEOUT = 1024,
    parameter int BYTE_TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  dbg_a,
    output logic [15:0] dbg_di,
    input  logic [15:0] dbg_do,
    output logic        dbg_we,
    output logic        dbg_rd,
    input  logic        dbg_ready,
    output logic        busy,
    output logic        err_timeout,
    output logic        rx_overrun
);
    localparam int AW = $clog2(ACCESS_TIMEOUT + 1);
    localparam int BW = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [AW-1:0] A_LAST = AW'(ACCESS_TIMEOUT - 1);
    localparam logic [AW-1:0] A_MAX  = AW'(ACCESS_TIMEOUT);
    localparam logic [BW-1:0] B_LAST = BW'(BYTE_TIMEOUT - 1);
    localparam logic [BW-1:0] B_MAX  = BW'(BYTE_TIMEOUT);
    localparam logic [1:0] OP_WR = 2'd1;
    localparam logic [1:0] OP_BR = 2'd3;

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_DLO, GET_DHI, GET_CNT,
        ACCESS, SEND_LO, SEND_HI, SEND_CODE
    } state_t;

    state_t        state, state_n;
    logic [1:0]    op;
    logic [15:0]   rdata;
    logic [7:0]    code;
    logic [8:0]    remain;
    logic [AW-1:0] acnt;
    logic [BW-1:0] bcnt;
    logic          in_get, acc_to, byte_to, opc_ok;

    assign in_get  = (state == GET_ADDR) || (state == GET_DLO) ||
                     (state == GET_DHI)  || (state == GET_CNT);
    assign acc_to  = (state == ACCESS) && !dbg_ready && (acnt == A_LAST);
    assign byte_to = in_get && !rx_valid && (bcnt == B_LAST);
    assign opc_ok  = (rx_data == 8'h01) || (rx_data == 8'h02) ||
                     (rx_data == 8'h03);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state plus strobe, transmit and status outputs
    always_comb begin
        state_n    = state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        dbg_we     = 1'b0;
        dbg_rd     = 1'b0;
        rx_overrun = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (rx_valid) state_n = opc_ok ? GET_ADDR : SEND_CODE;
            end
            GET_ADDR: begin
                if (byte_to) state_n = IDLE;
                else if (rx_valid) begin
                    if (op == OP_WR)      state_n = GET_DLO;
                    else if (op == OP_BR) state_n = GET_CNT;
                    else                  state_n = ACCESS;
                end
            end
            GET_DLO: begin
                if (byte_to)       state_n = IDLE;
                else if (rx_valid) state_n = GET_DHI;
            end
            GET_DHI, GET_CNT: begin
                if (byte_to)       state_n = IDLE;
                else if (rx_valid) state_n = ACCESS;
            end
            ACCESS: begin
                dbg_we     = (op == OP_WR);
                dbg_rd     = (op != OP_WR);
                rx_overrun = rx_valid;
                if (dbg_ready)
                    state_n = (op == OP_WR) ? SEND_CODE : SEND_LO;
                else if (acc_to)
                    state_n = SEND_CODE;
            end
            SEND_LO: begin
                tx_valid   = 1'b1;
                tx_data    = rdata[7:0];
                rx_overrun = rx_valid;
                if (tx_ready) state_n = SEND_HI;
            end
            SEND_HI: begin
                tx_valid   = 1'b1;
                tx_data    = rdata[15:8];
                rx_overrun = rx_valid;
                if (tx_ready)
                    state_n = (remain > 9'd1) ? ACCESS : IDLE;
            end
            SEND_CODE: begin
                tx_valid   = 1'b1;
                tx_data    = code;
                rx_overrun = rx_valid;
                if (tx_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Command fields, read data, response code and timeout counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op          <= '0;
            dbg_a       <= '0;
            dbg_di      <= '0;
            rdata       <= '0;
            code        <= '0;
            remain      <= '0;
            acnt        <= '0;
            bcnt        <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= acc_to;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        op   <= rx_data[1:0];
                        code <= 8'h15;
                    end
                end
                GET_ADDR: begin
                    if (rx_valid) begin
                        dbg_a  <= rx_data;
                        remain <= 9'd1;
                    end
                end
                GET_DLO: if (rx_valid) dbg_di[7:0]  <= rx_data;
                GET_DHI: if (rx_valid) dbg_di[15:8] <= rx_data;
                GET_CNT: begin
                    if (rx_valid)
                        remain <= (rx_data == 8'h00) ? 9'd256
                                                     : {1'b0, rx_data};
                end
                ACCESS: begin
                    if (dbg_ready) begin
                        if (op != OP_WR) rdata <= dbg_do;
                        code <= 8'h06;
                    end else if (acc_to) begin
                        code <= 8'hEE;
                    end
                end
                SEND_HI: if (tx_ready) remain <= remain - 9'd1;
                default: ;
            endcase
            if (state != ACCESS)
                acnt <= '0;
            else if (!dbg_ready && acnt != A_MAX)
                acnt <= acnt + AW'(1);
            if (!in_get || rx_valid)
                bcnt <= '0;
            else if (bcnt != B_MAX)
                bcnt <= bcnt + BW'(1);
        end
    end
endmodule

// File: tb/tb_dbg_uart_cmd.sv
// tb_dbg_uart_cmd: directed and randomized command sequences
// checked against a protocol-level reference model.
module tb_dbg_uart_cmd;
    localparam int AT    = 16;
    localparam int BT    = 40;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  dbg_a;
    logic [15:0] dbg_di;
    logic [15:0] dbg_do = 16'h0;
    logic        dbg_we;
    logic        dbg_rd;
    logic        dbg_ready = 1'b0;
    logic        busy;
    logic        err_timeout;
    logic        rx_overrun;

    dbg_uart_cmd #(.ACCESS_TIMEOUT(AT), .BYTE_TIMEOUT(BT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .dbg_a(dbg_a), .dbg_di(dbg_di), .dbg_do(dbg_do),
        .dbg_we(dbg_we), .dbg_rd(dbg_rd), .dbg_ready(dbg_ready),
        .busy(busy), .err_timeout(err_timeout),
        .rx_overrun(rx_overrun)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          dly  [DEPTH];
    logic [15:0] dval [DEPTH];

    int          acc_idx = 0;
    int          scyc = 0;
    logic        stb;
    logic        cw;
    logic [7:0]  ca;
    logic [15:0] cd;
    logic [7:0]  got_tx [$];
    logic [31:0] got_st [$];
    int n_to = 0, n_ovr = 0, n_both = 0, n_unst = 0, n_txun = 0;
    logic        ptxv = 1'b0, pacc = 1'b0;
    logic [7:0]  ptxd = 8'h0;
    int hold_n = 0, hold_tag = 0, seen_tag = 0, held = 0;

    int b_tx, b_st, b_to, b_ovr, b_both, b_unst, b_txun;
    logic [7:0]  exp_tx [$];
    logic [31:0] exp_st [$];
    int          exp_to;

    function automatic logic [31:0] pk(input logic w,
        input logic [7:0] a, input logic [15:0] d, input int len);
        logic [6:0] l;
        l = 7'(len);
        return {w, a, d, l};
    endfunction

    // Register-block and transmitter model plus bus monitor
    always @(negedge clk) begin
        stb = dbg_we | dbg_rd;
        dbg_ready = stb && (scyc == dly[acc_idx % DEPTH]);
        dbg_do = dval[acc_idx % DEPTH];
        if (seen_tag != hold_tag) begin
            seen_tag = hold_tag;
            held = 0;
        end
        if (tx_valid && held < hold_n) begin
            tx_ready = 1'b0;
            held++;
        end else begin
            tx_ready = ($urandom_range(0, 2) != 0);
        end
        #1;
        if (tx_valid && tx_ready) got_tx.push_back(tx_data);
        if (ptxv && !pacc && (!tx_valid || tx_data !== ptxd)) n_txun++;
        ptxv = tx_valid;
        pacc = tx_valid && tx_ready;
        ptxd = tx_data;
        if (dbg_we && dbg_rd) n_both++;
        if (err_timeout) n_to++;
        if (rx_overrun) n_ovr++;
        if (stb) begin
            if (scyc == 0) begin
                cw = dbg_we;
                ca = dbg_a;
                cd = dbg_we ? dbg_di : 16'h0;
            end else if (dbg_we !== cw || dbg_a !== ca ||
                         (cw && dbg_di !== cd)) begin
                n_unst++;
            end
            scyc++;
            if (dbg_ready) begin
                got_st.push_back(pk(cw, ca, cd, scyc));
                acc_idx++;
                scyc = 0;
            end
        end else if (scyc > 0) begin
            got_st.push_back(pk(cw, ca, cd, scyc));
            acc_idx++;
            scyc = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        b_tx = got_tx.size();
        b_st = got_st.size();
        b_to = n_to;
        b_ovr = n_ovr;
        b_both = n_both;
        b_unst = n_unst;
        b_txun = n_txun;
    endtask

    // Expected response bytes and bus accesses for one command
    task automatic model(input logic [7:0] op, input logic [7:0] a,
                         input logic [15:0] d, input logic [7:0] cnt);
        int s, n, i;
        s = acc_idx;
        exp_tx.delete();
        exp_st.delete();
        exp_to = 0;
        if (op == 8'h01) begin
            i = s % DEPTH;
            if (dly[i] >= AT) begin
                exp_st.push_back(pk(1'b1, a, d, AT));
                exp_tx.push_back(8'hEE);
                exp_to = 1;
            end else begin
                exp_st.push_back(pk(1'b1, a, d, dly[i] + 1));
                exp_tx.push_back(8'h06);
            end
        end else if (op == 8'h02 || op == 8'h03) begin
            n = (op == 8'h02) ? 1 : ((cnt == 8'h0) ? 256 : int'(cnt));
            for (int k = 0; k < n; k++) begin
                i = (s + k) % DEPTH;
                if (dly[i] >= AT) begin
                    exp_st.push_back(pk(1'b0, a, 16'h0, AT));
                    exp_tx.push_back(8'hEE);
                    exp_to = 1;
                    break;
                end
                exp_st.push_back(pk(1'b0, a, 16'h0, dly[i] + 1));
                exp_tx.push_back(dval[i][7:0]);
                exp_tx.push_back(dval[i][15:8]);
            end
        end else begin
            exp_tx.push_back(8'h15);
        end
    endtask

    task automatic compare(input string tag, input int ovr);
        int ntx, nst;
        ntx = got_tx.size() - b_tx;
        nst = got_st.size() - b_st;
        chk({tag, "_ntx"}, ntx, exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < ntx; i++)
            chk($sformatf("%s_tx%0d", tag, i),
                32'(got_tx[b_tx + i]), 32'(exp_tx[i]));
        chk({tag, "_nacc"}, nst, exp_st.size());
        for (int i = 0; i < exp_st.size() && i < nst; i++)
            chk($sformatf("%s_acc%0d", tag, i),
                got_st[b_st + i], exp_st[i]);
        chk({tag, "_errto"}, n_to - b_to, exp_to);
        chk({tag, "_ovr"}, n_ovr - b_ovr, ovr);
        chk({tag, "_both"}, n_both - b_both, 0);
        chk({tag, "_busstab"}, n_unst - b_unst, 0);
        chk({tag, "_txstab"}, n_txun - b_txun, 0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        #2;
        while (busy && n < 20000) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_cmd(input string tag, input logic [7:0] b0,
        input logic [7:0] b1, input logic [7:0] b2,
        input logic [7:0] b3, input int nb, input int ovr_at);
        logic [7:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        sync();
        model(b0, b1, {b3, b2}, b2);
        for (int i = 0; i < nb; i++) begin
            put(b[i]);
            if (i < nb - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        if (ovr_at > 0) begin
            repeat (ovr_at) @(negedge clk);
            put(8'h01);
        end
        wait_idle(tag);
        compare(tag, (ovr_at > 0) ? 1 : 0);
    endtask

    initial begin
        int s, r;
        logic [7:0] a, x, y;
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h0;
        for (int i = 0; i < DEPTH; i++) begin
            dval[i] = 16'($urandom);
            if ($urandom_range(0, 15) == 0)
                dly[i] = AT - 1 + int'($urandom_range(0, 1));
            else
                dly[i] = int'($urandom_range(0, 4));
        end
        repeat (3) @(negedge clk);
        #2;
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_dbg_a", 32'(dbg_a), 32'd0);
        chk("rst_dbg_di", 32'(dbg_di), 32'd0);
        chk("rst_dbg_we", 32'(dbg_we), 32'd0);
        chk("rst_dbg_rd", 32'(dbg_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_to", 32'(err_timeout), 32'd0);
        chk("rst_ovr", 32'(rx_overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        dly[acc_idx % DEPTH] = 2;
        do_cmd("wr", 8'h01, 8'h1B, 8'h34, 8'h12, 4, 0);

        s = acc_idx % DEPTH;
        dly[s] = 1;
        dval[s] = 16'hBEEF;
        hold_n = 5;
        hold_tag++;
        do_cmd("rd", 8'h02, 8'h12, 8'h00, 8'h00, 2, 0);
        hold_n = 0;
        hold_tag++;

        s = acc_idx;
        for (int k = 0; k < 3; k++) begin
            dly[(s + k) % DEPTH] = 4;
            dval[(s + k) % DEPTH] = 16'(k + 1);
        end
        do_cmd("burst", 8'h03, 8'h20, 8'h03, 8'h00, 3, 0);

        dly[acc_idx % DEPTH] = AT;
        do_cmd("tmo", 8'h02, 8'h05, 8'h00, 8'h00, 2, 0);

        dly[acc_idx % DEPTH] = AT - 1;
        do_cmd("edge", 8'h02, 8'h07, 8'h00, 8'h00, 2, 0);

        s = acc_idx;
        dly[s % DEPTH] = 1;
        dly[(s + 1) % DEPTH] = 1;
        dly[(s + 2) % DEPTH] = AT;
        dly[(s + 3) % DEPTH] = 0;
        do_cmd("brto", 8'h03, 8'h20, 8'h04, 8'h00, 3, 0);

        do_cmd("nak", 8'h7F, 8'h00, 8'h00, 8'h00, 1, 0);

        sync();
        exp_tx.delete();
        exp_st.delete();
        exp_to = 0;
        put(8'h01);
        put(8'h10);
        repeat (BT - 1) @(negedge clk);
        #2;
        chk("btmo_busy_pre", 32'(busy), 32'd1);
        @(negedge clk);
        #2;
        chk("btmo_busy", 32'(busy), 32'd0);
        @(negedge clk);
        compare("btmo", 0);

        dly[acc_idx % DEPTH] = 2;
        do_cmd("after", 8'h02, 8'h10, 8'h00, 8'h00, 2, 0);

        dly[acc_idx % DEPTH] = 6;
        do_cmd("ovr", 8'h02, 8'h33, 8'h00, 8'h00, 2, 1);

        dly[acc_idx % DEPTH] = 12;
        put(8'h02);
        put(8'h05);
        @(negedge clk);
        #2;
        chk("mrst_rd_pre", 32'(dbg_rd), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        chk("mrst_rd", 32'(dbg_rd), 32'd0);
        chk("mrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            a = 8'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            if (r < 3)
                do_cmd($sformatf("r%0d_wr", n), 8'h01, a, x, y, 4, 0);
            else if (r < 6)
                do_cmd($sformatf("r%0d_rd", n), 8'h02, a, 8'h0, 8'h0,
                       2, 0);
            else if (r < 9)
                do_cmd($sformatf("r%0d_br", n), 8'h03, a,
                       8'($urandom_range(1, 6)), 8'h0, 3, 0);
            else
                do_cmd($sformatf("r%0d_nak", n),
                       8'($urandom_range(4, 255)), 8'h0, 8'h0, 8'h0,
                       1, 0);
        end

        s = acc_idx;
        for (int k = 0; k < 256; k++) dly[(s + k) % DEPTH] = 0;
        do_cmd("b256", 8'h03, 8'h44, 8'h00, 8'h00, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
